ray_column_flattener: RTL and testbench

//  Upstream feeder of the double-buffered frame buffer. Accepts one ray-cast column

---
 rtl/ray_column_flattener.sv | 156 +++++++++++++++
 tb/tb_ray_column_flattener.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_column_flattener.sv
// rtl/ray_column_flattener.sv - expands one ray-cast column into ceiling/wall/floor RGB565 pixel writes
// Optional feature macro: SIDE_SHADE_EN (halves the wall colour of y-side hits).
module ray_column_flattener #(
  parameter int          SCREEN_WIDTH  = 320,
  parameter int          SCREEN_HEIGHT = 180,
  parameter logic [15:0] CEILING_COLOR = 16'h39E7,
  parameter logic [15:0] FLOOR_COLOR   = 16'h7BEF
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        col_valid_in,
  output logic        col_ready_out,
  input  logic [8:0]  col_index_in,
  input  logic [7:0]  wall_height_in,
  input  logic [15:0] wall_color_in,
  input  logic        wall_side_in,
  input  logic        col_last_in,
  output logic [15:0] ray_address_out,
  output logic [15:0] ray_pixel_out,
  output logic        ray_valid_out,
  output logic        ray_last_pixel_out
);

  localparam logic [8:0]  HEIGHT_L = 9'(SCREEN_HEIGHT);
  localparam logic [8:0]  LAST_ROW = 9'(SCREEN_HEIGHT - 1);
  localparam logic [9:0]  WIDTH_X  = 10'(SCREEN_WIDTH);
  localparam logic [15:0] WIDTH_A  = 16'(SCREEN_WIDTH);

  typedef enum logic {IDLE, DRAW} state_t;

  state_t      state_q, state_d;
  logic [8:0]  y_q, y_d;
  logic [8:0]  top_q, top_d;
  logic [8:0]  bottom_q, bottom_d;
  logic [15:0] wall_q, wall_d;
  logic        last_col_q, last_col_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] pix_q, pix_d;
  logic        valid_q, valid_d;
  logic        last_pulse_q, last_pulse_d;

  logic [8:0]  h_clamp;
  logic [8:0]  top_in;
  logic [8:0]  bottom_in;
  logic [15:0] wall_in;
  logic        at_last_row;
  logic        accept;
  logic        in_range;

  function automatic logic [15:0] row_pixel(input logic [8:0] y, input logic [8:0] top,
                                            input logic [8:0] bottom, input logic [15:0] wall);
    if (y < top) begin
      return CEILING_COLOR;
    end else if (y < bottom) begin
      return wall;
    end
    return FLOOR_COLOR;
  endfunction

  // Wall span geometry for the column being offered, centred vertically.
  always_comb begin
    h_clamp   = (9'(wall_height_in) >= HEIGHT_L) ? HEIGHT_L : 9'(wall_height_in);
    top_in    = (HEIGHT_L - h_clamp) >> 1;
    bottom_in = top_in + h_clamp;
  end

`ifdef SIDE_SHADE_EN
  assign wall_in = wall_side_in
                 ? {1'b0, wall_color_in[15:12], 1'b0, wall_color_in[10:6], 1'b0, wall_color_in[4:1]}
                 : wall_color_in;
`else
  logic unused_side;
  assign unused_side = wall_side_in;
  assign wall_in     = wall_color_in;
`endif

  assign at_last_row   = (state_q == DRAW) && (y_q == LAST_ROW);
  assign col_ready_out = !rst_in && ((state_q == IDLE) || at_last_row);
  assign accept        = col_valid_in && col_ready_out;
  assign in_range      = {1'b0, col_index_in} < WIDTH_X;

  always_comb begin
    state_d      = state_q;
    y_d          = y_q;
    top_d        = top_q;
    bottom_d     = bottom_q;
    wall_d       = wall_q;
    last_col_d   = last_col_q;
    addr_d       = addr_q;
    pix_d        = pix_q;
    valid_d      = 1'b0;
    last_pulse_d = 1'b0;

    if (accept) begin
      if (in_range) begin
        // Row 0 of the new column goes straight to the outputs on the handshake edge.
        state_d      = DRAW;
        y_d          = 9'd0;
        top_d        = top_in;
        bottom_d     = bottom_in;
        wall_d       = wall_in;
        last_col_d   = col_last_in;
        addr_d       = {7'd0, col_index_in};
        pix_d        = row_pixel(9'd0, top_in, bottom_in, wall_in);
        valid_d      = 1'b1;
        last_pulse_d = col_last_in && (LAST_ROW == 9'd0);
      end else begin
        // Off-screen column: nothing to draw, but the end-of-frame marker still travels.
        state_d      = IDLE;
        last_pulse_d = col_last_in;
      end
    end else if (state_q == DRAW) begin
      if (at_last_row) begin
        state_d = IDLE;
      end else begin
        y_d          = y_q + 9'd1;
        addr_d       = addr_q + WIDTH_A;
        pix_d        = row_pixel(y_q + 9'd1, top_q, bottom_q, wall_q);
        valid_d      = 1'b1;
        last_pulse_d = last_col_q && ((y_q + 9'd1) == LAST_ROW);
      end
    end
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      y_q          <= 9'd0;
      top_q        <= 9'd0;
      bottom_q     <= 9'd0;
      wall_q       <= 16'd0;
      last_col_q   <= 1'b0;
      addr_q       <= 16'd0;
      pix_q        <= 16'd0;
      valid_q      <= 1'b0;
      last_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      y_q          <= y_d;
      top_q        <= top_d;
      bottom_q     <= bottom_d;
      wall_q       <= wall_d;
      last_col_q   <= last_col_d;
      addr_q       <= addr_d;
      pix_q        <= pix_d;
      valid_q      <= valid_d;
      last_pulse_q <= last_pulse_d;
    end
  end

  assign ray_address_out    = addr_q;
  assign ray_pixel_out      = pix_q;
  assign ray_valid_out      = valid_q;
  assign ray_last_pixel_out = last_pulse_q;

endmodule

// File: tb/tb_ray_column_flattener.sv
// tb/tb_ray_column_flattener.sv - self-checking bench for ray_column_flattener
module tb_ray_column_flattener;

  localparam int          W     = 320;
  localparam int          H     = 180;
  localparam logic [15:0] CEIL  = 16'h39E7;
  localparam logic [15:0] FLOOR = 16'h7BEF;
`ifdef SIDE_SHADE_EN
  localparam bit SHADE = 1'b1;
`else
  localparam bit SHADE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cv = 1'b0;
  logic [8:0]  cx = '0;
  logic [7:0]  ch = '0;
  logic [15:0] cc = '0;
  logic        cs = 1'b0;
  logic        cl = 1'b0;
  logic        ready_o;
  logic [15:0] addr_o;
  logic [15:0] pix_o;
  logic        valid_o;
  logic        last_o;

  always #5 clk = ~clk;

  ray_column_flattener dut (
    .pixel_clk_in      (clk),
    .rst_in            (rst),
    .col_valid_in      (cv),
    .col_ready_out     (ready_o),
    .col_index_in      (cx),
    .wall_height_in    (ch),
    .wall_color_in     (cc),
    .wall_side_in      (cs),
    .col_last_in       (cl),
    .ray_address_out   (addr_o),
    .ray_pixel_out     (pix_o),
    .ray_valid_out     (valid_o),
    .ray_last_pixel_out(last_o)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] pix;
    logic        last;
    int          y;
  } exp_t;

  typedef struct {
    int          x;
    int          h;
    logic [15:0] c;
    logic        s;
    int          n_ceil;
    int          n_wall;
    int          n_floor;
  } vec_t;

  exp_t        expq[$];
  int          passed = 0;
  int          total = 0;
  logic [15:0] hold_addr = '0;
  logic [15:0] hold_pix = '0;
  int          cnt_ceil = 0, cnt_wall = 0, cnt_floor = 0;
  int          run_len = 0, max_run = 0, last_cnt = 0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] model_pix(input int y, input int h, input logic [15:0] c,
                                            input logic s);
    int          hc;
    int          top;
    logic [15:0] wc;
    hc  = (h > H) ? H : h;
    top = (H - hc) / 2;
    wc  = (SHADE && s) ? {1'b0, c[15:12], 1'b0, c[10:6], 1'b0, c[4:1]} : c;
    if (y < top) return CEIL;
    if (y < top + hc) return wc;
    return FLOOR;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !rst) begin
      if (last_o) last_cnt++;
      if (valid_o) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (expq.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          check("addr", 32'(addr_o), 32'(e.addr));
          check("pixel", 32'(pix_o), 32'(e.pix));
          check("last_pixel", 32'(last_o), 32'(e.last));
          check("ready_in_draw", 32'(ready_o), 32'(e.y == H - 1));
          hold_addr = e.addr;
          hold_pix  = e.pix;
          if (pix_o == CEIL) cnt_ceil++;
          else if (pix_o == FLOOR) cnt_floor++;
          else cnt_wall++;
        end
      end else begin
        run_len = 0;
        check("hold_addr", 32'(addr_o), 32'(hold_addr));
        check("hold_pixel", 32'(pix_o), 32'(hold_pix));
        check("idle_ready", 32'(ready_o), 32'd1);
      end
    end
  end

  task automatic send(input int x, input int h, input logic [15:0] c, input logic s,
                      input logic l);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    #1;
    cv = 1'b1;
    cx = x[8:0];
    ch = h[7:0];
    cc = c;
    cs = s;
    cl = l;
    while (!ready_o && guard < 500) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!ready_o) begin
      check("handshake_timeout", 32'd0, 32'd1);
      cv = 1'b0;
      return;
    end
    if (x < W) begin
      for (int y = 0; y < H; y++) begin
        e.addr = 16'(x + W * y);
        e.pix  = model_pix(y, h, c, s);
        e.last = l && (y == H - 1);
        e.y    = y;
        expq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    cv = 1'b0;
    cx = 9'($urandom);
    ch = 8'($urandom);
    cc = 16'($urandom);
    cs = 1'($urandom);
    cl = 1'($urandom);
    if (x < W) begin
      check("latency_valid", 32'(valid_o), 32'd1);
      check("latency_addr", 32'(addr_o), 32'(x));
    end else begin
      check("oor_valid", 32'(valid_o), 32'd0);
      check("oor_last", 32'(last_o), 32'(l));
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((expq.size() != 0 || valid_o) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    check("drain", 32'(expq.size()), 32'd0);
  endtask

  vec_t vecs[8];
  int   exp_lasts;

  initial begin
    vecs[0] = '{5,   60,  16'h07E0, 1'b0, 60, 60,  60};
    vecs[1] = '{100, 0,   16'hF800, 1'b0, 90, 0,   90};
    vecs[2] = '{319, 255, 16'h001F, 1'b0, 0,  180, 0};
    vecs[3] = '{17,  1,   16'hABCD, 1'b0, 89, 1,   90};
    vecs[4] = '{200, 179, 16'h1234, 1'b0, 0,  179, 1};
    vecs[5] = '{44,  181, 16'hF800, 1'b1, 0,  180, 0};
    vecs[6] = '{250, 2,   16'h07E0, 1'b0, 89, 2,   89};
    vecs[7] = '{3,   180, 16'hFFFF, 1'b0, 0,  180, 0};

    // reset state
    #12;
    check("rst_addr", 32'(addr_o), 32'd0);
    check("rst_pixel", 32'(pix_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_last", 32'(last_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    #1;
    check("ready_after_reset", 32'(ready_o), 32'd1);

    // full-height column at x=0
    cnt_ceil = 0; cnt_wall = 0; cnt_floor = 0; last_cnt = 0;
    send(0, 180, 16'hF800, 1'b0, 1'b0);
    wait_drain();
    check("t1_wall", 32'(cnt_wall), 32'd180);
    check("t1_ceil", 32'(cnt_ceil), 32'd0);
    check("t1_last_pulses", 32'(last_cnt), 32'd0);
    check("t1_final_addr", 32'(hold_addr), 32'd57280);

    for (int i = 0; i < 8; i++) begin
      cnt_ceil = 0; cnt_wall = 0; cnt_floor = 0;
      send(vecs[i].x, vecs[i].h, vecs[i].c, vecs[i].s, 1'b0);
      wait_drain();
      check($sformatf("vec%0d_ceil", i), 32'(cnt_ceil), 32'(vecs[i].n_ceil));
      check($sformatf("vec%0d_wall", i), 32'(cnt_wall), 32'(vecs[i].n_wall));
      check($sformatf("vec%0d_floor", i), 32'(cnt_floor), 32'(vecs[i].n_floor));
    end

    // back-to-back final columns of the sweep
    run_len = 0; max_run = 0; last_cnt = 0;
    send(318, 100, 16'hF800, 1'b0, 1'b0);
    send(319, 100, 16'h07E0, 1'b0, 1'b1);
    wait_drain();
    check("b2b_run", 32'(max_run), 32'd360);
    check("b2b_last_pulses", 32'(last_cnt), 32'd1);
    check("b2b_final_addr", 32'(hold_addr), 32'd57599);

    // off-screen columns
    last_cnt = 0;
    send(400, 50, 16'hFFFF, 1'b0, 1'b1);
    check("oor_hold_addr", 32'(addr_o), 32'd57599);
    @(posedge clk);
    #1;
    check("oor_last_one_cycle", 32'(last_o), 32'd0);
    send(333, 90, 16'h1111, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("oor_last_pulses", 32'(last_cnt), 32'd1);
    check("oor_no_writes", 32'(expq.size()), 32'd0);

    // reset mid-column
    send(7, 100, 16'hF800, 1'b0, 1'b0);
    repeat (50) @(posedge clk);
    #2;
    check("pre_rst_addr", 32'(addr_o), 32'(7 + W * 50));
    rst = 1'b1;
    expq.delete();
    hold_addr = '0;
    hold_pix  = '0;
    #1;
    check("midrst_addr", 32'(addr_o), 32'd0);
    check("midrst_pixel", 32'(pix_o), 32'd0);
    check("midrst_valid", 32'(valid_o), 32'd0);
    check("midrst_ready", 32'(ready_o), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("ready_after_midrst", 32'(ready_o), 32'd1);
    last_cnt = 0;
    send(9, 60, 16'h07E0, 1'b0, 1'b1);
    wait_drain();
    check("post_rst_last", 32'(last_cnt), 32'd1);

    // randomized columns against the model
    last_cnt = 0;
    exp_lasts = 0;
    for (int i = 0; i < 40; i++) begin
      int          x, h, gap;
      logic [15:0] c;
      logic        s, l;
      x   = $urandom_range(0, 339);
      h   = $urandom_range(0, 255);
      c   = 16'($urandom);
      s   = 1'($urandom);
      l   = ($urandom_range(0, 7) == 0);
      gap = $urandom_range(0, 3);
      if (l) exp_lasts++;
      repeat (gap) @(negedge clk);
      send(x, h, c, s, l);
    end
    wait_drain();
    check("rand_last_pulses", 32'(last_cnt), 32'(exp_lasts));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
